// File: rtl/enemy_ai_ctrl_if.sv
// rtl/enemy_ai_ctrl_if.sv - game-side bundle between the world and the enemy controller
//
// Purpose : groups the per-frame game inputs and the enemy outputs that feed
//           the enemy-bullet stage into one interface.
// Signals : frame_tick  1-cycle pulse per game frame
//           enable      game running
//           yPlayer     player centre y (signed 10b)
//           bullet_busy enemy bullet exists
//           pb_active   player bullet exists
//           pb_x        player bullet x (signed 11b)
//           attack      fire request pulse
//           defend      guard level
//           xEnemy      enemy x (signed 11b)
//           yEnemy      enemy centre y (signed 10b)
// Modports: master = game side (drives inputs), slave = controller.

interface enemy_ai_ctrl_if;
   logic               frame_tick;
   logic               enable;
   logic signed [9:0]  yPlayer;
   logic               bullet_busy;
   logic               pb_active;
   logic signed [10:0] pb_x;
   logic               attack;
   logic               defend;
   logic signed [10:0] xEnemy;
   logic signed [9:0]  yEnemy;

   modport master (
      output frame_tick, enable, yPlayer, bullet_busy, pb_active, pb_x,
      input  attack, defend, xEnemy, yEnemy
   );

   modport slave (
      input  frame_tick, enable, yPlayer, bullet_busy, pb_active, pb_x,
      output attack, defend, xEnemy, yEnemy
   );
endinterface

// File: rtl/enemy_ai_ctrl.sv
// rtl/enemy_ai_ctrl.sv - enemy behaviour controller feeding the enemy-bullet stage
//
// Purpose : tracks the player vertically, requests a shot when aligned and the
//           enemy bullet is free, and raises a timed guard against incoming
//           player bullets. Advances once per game frame; a 16-bit LFSR adds a
//           pseudo-random extra cooldown after every shot.
// Ports   : clk    system clock
//           rst_n  asynchronous active-low reset
//           bus    enemy_ai_ctrl_if.slave (frame_tick, enable, yPlayer,
//                  bullet_busy, pb_active, pb_x in; attack, defend, xEnemy,
//                  yEnemy out, all outputs registered)

module enemy_ai_ctrl #(
   parameter int         X_START      = 280,
   parameter int         Y_LIMIT      = 200,
   parameter int         STEP_Y       = 2,
   parameter int         AIM_TOL      = 8,
   parameter int         COOL_MIN     = 20,
   parameter logic [7:0] COOL_MASK    = 8'h1F,
   parameter int         GUARD_DIST   = 120,
   parameter int         GUARD_FRAMES = 30,
   parameter int         GUARD_RCHG   = 60
) (
   input logic            clk,
   input logic            rst_n,
   enemy_ai_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRACK,
      S_FIRE,
      S_GUARD
   } state_t;

   localparam logic signed [10:0] STEP_S = 11'(STEP_Y);
   localparam logic signed [10:0] YLIM_S = 11'(Y_LIMIT);
   localparam logic signed [10:0] AIM_S  = 11'(AIM_TOL);
   localparam logic signed [10:0] THR_S  = 11'(X_START - GUARD_DIST);

   state_t            state_q, state_d;
   logic              attack_q, attack_d;
   logic              defend_q, defend_d;
   logic signed [9:0] y_q, y_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [7:0]        cool_q, cool_d;
   logic [4:0]        guard_q, guard_d;
   logic [5:0]        rchg_q, rchg_d;

   logic signed [10:0] dy;
   logic signed [10:0] step;
   logic signed [10:0] y_sum;
   logic signed [10:0] y_clamp;
   logic signed [9:0]  y_mov;
   logic               aligned;
   logic               threat;
   logic [15:0]        lfsr_next;
   logic [7:0]         cool_reload;

   // Datapath helpers: move toward the player by at most STEP_Y, then keep
   // the result inside the playfield. dy is taken before the move so the
   // fire decision sees the same geometry that produced this frame's move.
   always_comb begin
      dy      = $signed({bus.yPlayer[9], bus.yPlayer}) - $signed({y_q[9], y_q});
      step    = dy;
      if (dy > STEP_S) begin
         step = STEP_S;
      end else if (dy < -STEP_S) begin
         step = -STEP_S;
      end
      y_sum   = $signed({y_q[9], y_q}) + step;
      y_clamp = y_sum;
      if (y_sum > YLIM_S) begin
         y_clamp = YLIM_S;
      end else if (y_sum < -YLIM_S) begin
         y_clamp = -YLIM_S;
      end
      y_mov       = y_clamp[9:0];
      aligned     = (dy >= -AIM_S) && (dy <= AIM_S);
      threat      = bus.pb_active && (bus.pb_x > THR_S);
      // Fibonacci form, taps 16,14,13,11 counted from the output end (bit 0).
      lfsr_next   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      cool_reload = 8'(COOL_MIN) + (lfsr_q[7:0] & COOL_MASK);
   end

   always_comb begin
      state_d  = state_q;
      attack_d = 1'b0;
      defend_d = 1'b0;
      y_d      = y_q;
      lfsr_d   = lfsr_q;
      cool_d   = cool_q;
      guard_d  = guard_q;
      rchg_d   = rchg_q;

      case (state_q)
         S_IDLE: begin
            if (bus.enable) begin
               state_d = S_TRACK;
            end
         end

         S_TRACK: begin
            if (!bus.enable) begin
               state_d = S_IDLE;
            end else if (bus.frame_tick) begin
               lfsr_d = lfsr_next;
               if (threat && (rchg_q == 6'd0)) begin
                  state_d  = S_GUARD;
                  guard_d  = 5'(GUARD_FRAMES);
                  defend_d = 1'b1;
               end else begin
                  y_d = y_mov;
                  if (rchg_q != 6'd0) begin
                     rchg_d = rchg_q - 6'd1;
                  end
                  if ((cool_q == 8'd0) && !bus.bullet_busy && aligned) begin
                     state_d  = S_FIRE;
                     attack_d = 1'b1;
                  end else if (cool_q != 8'd0) begin
                     cool_d = cool_q - 8'd1;
                  end
               end
            end
         end

         // One-cycle shot; ticks landing here are dropped on purpose. The
         // cooldown is reloaded even if the game stops, since the shot left.
         S_FIRE: begin
            cool_d  = cool_reload;
            state_d = bus.enable ? S_TRACK : S_IDLE;
         end

         S_GUARD: begin
            defend_d = 1'b1;
            if (!bus.enable) begin
               state_d  = S_IDLE;
               defend_d = 1'b0;
            end else if (bus.frame_tick) begin
               lfsr_d  = lfsr_next;
               guard_d = guard_q - 5'd1;
               if ((guard_q <= 5'd1) || !threat) begin
                  state_d  = S_TRACK;
                  guard_d  = 5'd0;
                  rchg_d   = 6'(GUARD_RCHG);
                  defend_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         attack_q <= 1'b0;
         defend_q <= 1'b0;
         y_q      <= '0;
         lfsr_q   <= 16'hACE1;
         cool_q   <= 8'(COOL_MIN);
         guard_q  <= '0;
         rchg_q   <= '0;
      end else begin
         state_q  <= state_d;
         attack_q <= attack_d;
         defend_q <= defend_d;
         y_q      <= y_d;
         lfsr_q   <= lfsr_d;
         cool_q   <= cool_d;
         guard_q  <= guard_d;
         rchg_q   <= rchg_d;
      end
   end

   assign bus.attack = attack_q;
   assign bus.defend = defend_q;
   assign bus.yEnemy = y_q;
   assign bus.xEnemy = 11'(X_START);

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// tb/tb_enemy_ai_ctrl.sv - scoreboard bench for enemy_ai_ctrl

module tb_enemy_ai_ctrl;

   localparam int K_ATTACK = 0;
   localparam int K_RISE   = 1;
   localparam int K_FALL   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   enemy_ai_ctrl_if bus_if ();

   enemy_ai_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   int n_vec = 0;
   int n_bad = 0;
   int tick_no = 0;
   int exp_kind[$];
   int exp_tick[$];
   logic prev_def = 1'b0;

   function automatic logic [15:0] lfsr_after(input int n);
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < n; i++) begin
         l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      end
      return l;
   endfunction

   function automatic int cool_from(input int n_shifts);
      logic [15:0] l;
      l = lfsr_after(n_shifts);
      return 20 + int'(l[4:0]);
   endfunction

   function automatic void push_ev(input int kind, input int t);
      exp_kind.push_back(kind);
      exp_tick.push_back(t);
   endfunction

   function automatic void check_event(input int kind);
      int ek;
      int et;
      n_vec++;
      if (exp_kind.size() == 0) begin
         n_bad++;
         $display("FAIL event_unexpected: got kind %0d at tick %0d, required no event", kind, tick_no);
      end else begin
         ek = exp_kind.pop_front();
         et = exp_tick.pop_front();
         if (ek != kind || et != tick_no) begin
            n_bad++;
            $display("FAIL event_order: got kind %0d at tick %0d, required kind %0d at tick %0d",
                     kind, tick_no, ek, et);
         end
      end
   endfunction

   // Monitor: every attack cycle and every defend edge is an output event.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_def = 1'b0;
      end else begin
         if (bus_if.attack) begin
            check_event(K_ATTACK);
         end
         if (bus_if.defend !== prev_def) begin
            check_event(bus_if.defend ? K_RISE : K_FALL);
            prev_def = bus_if.defend;
         end
      end
   end

   task automatic chk(input string name, input int got, input int req);
      n_vec++;
      if (got != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1 bus_if.frame_tick = 1'b1;
      @(posedge clk);
      tick_no++;
      #1 bus_if.frame_tick = 1'b0;
   endtask

   task automatic ticks_until(input int t);
      while (tick_no < t) tick();
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int f2, f3, c, g;

      bus_if.frame_tick  = 1'b0;
      bus_if.enable      = 1'b0;
      bus_if.yPlayer     = 10'sd0;
      bus_if.bullet_busy = 1'b0;
      bus_if.pb_active   = 1'b0;
      bus_if.pb_x        = 11'sd0;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);

      chk("reset_attack", int'(bus_if.attack), 0);
      chk("reset_defend", int'(bus_if.defend), 0);
      chk("reset_yEnemy", int'(bus_if.yEnemy), 0);
      chk("reset_xEnemy", int'(bus_if.xEnemy), 280);

      // First shot: cooldown 20 consumed by ticks 1..20, tick 21 fires.
      bus_if.enable = 1'b1;
      cycles(2);
      push_ev(K_ATTACK, 21);
      f2 = 22 + cool_from(21);
      push_ev(K_ATTACK, f2);
      ticks_until(f2);

      // Tracking and clamp, with the bullet stage busy so no shots interfere.
      bus_if.bullet_busy = 1'b1;
      bus_if.yPlayer = 10'sd100;
      repeat (25) tick();
      chk("track_25", int'(bus_if.yEnemy), 50);
      repeat (25) tick();
      chk("track_50", int'(bus_if.yEnemy), 100);
      bus_if.yPlayer = 10'sd300;
      repeat (60) tick();
      chk("clamp_200", int'(bus_if.yEnemy), 200);
      bus_if.yPlayer = 10'sd197;
      tick();
      chk("step_down", int'(bus_if.yEnemy), 198);
      tick();
      chk("no_overshoot", int'(bus_if.yEnemy), 197);

      // Aligned, cooldown expired, bullet busy: no shot; threat boundary
      // (pb_x == 160 is not a threat, negative pb_x is not a threat).
      bus_if.pb_active = 1'b1;
      bus_if.pb_x = 11'sd160;
      tick();
      bus_if.pb_x = -11'sd500;
      tick();
      bus_if.pb_active = 1'b0;
      bus_if.pb_x = 11'sd300;
      tick();
      bus_if.bullet_busy = 1'b0;
      f3 = tick_no + 1;
      push_ev(K_ATTACK, f3);
      tick();

      // Guard for the full 30 frames, position frozen, cooldown frozen.
      c = cool_from(f3);
      bus_if.pb_active = 1'b1;
      bus_if.pb_x = 11'sd200;
      bus_if.yPlayer = 10'sd150;
      push_ev(K_RISE, f3 + 1);
      push_ev(K_FALL, f3 + 31);
      ticks_until(f3 + 31);
      chk("guard_frozen_y", int'(bus_if.yEnemy), 197);
      bus_if.yPlayer = 10'sd197;
      push_ev(K_ATTACK, f3 + 32 + c);
      ticks_until(f3 + 32 + c);
      bus_if.bullet_busy = 1'b1;
      // Threat persists; recharge holds off the next guard for 60 frames.
      g = f3 + 92;
      push_ev(K_RISE, g);
      ticks_until(g);

      // Threat withdrawn: guard ends on the 5th guard tick.
      push_ev(K_FALL, g + 5);
      repeat (4) tick();
      bus_if.pb_active = 1'b0;
      tick();

      // Enable falls during guard.
      bus_if.pb_active = 1'b1;
      push_ev(K_RISE, g + 66);
      ticks_until(g + 66);
      push_ev(K_FALL, g + 66);
      @(posedge clk);
      #1 bus_if.enable = 1'b0;
      cycles(2);
      chk("disable_defend", int'(bus_if.defend), 0);
      tick();
      tick();
      chk("disable_hold_y", int'(bus_if.yEnemy), 197);
      chk("disable_no_guard", int'(bus_if.defend), 0);
      bus_if.enable = 1'b1;
      cycles(2);
      push_ev(K_RISE, g + 69);
      tick();
      bus_if.pb_active = 1'b0;
      push_ev(K_FALL, g + 70);
      tick();

      // Reset while the shot is on the wire.
      bus_if.bullet_busy = 1'b0;
      @(posedge clk);
      #1 bus_if.frame_tick = 1'b1;
      @(posedge clk);
      tick_no++;
      #1 bus_if.frame_tick = 1'b0;
      chk("fire_before_reset", int'(bus_if.attack), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_attack", int'(bus_if.attack), 0);
      chk("async_reset_y", int'(bus_if.yEnemy), 0);
      cycles(2);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_reset_defend", int'(bus_if.defend), 0);
      cycles(3);

      chk("events_outstanding", exp_kind.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
